cpu_68k_irq_ctrl: RTL and testbench

CPU_68K_IRQ_CTRL -- requirements
Module: cpu_68k_irq_ctrl

---
 rtl/cpu_68k_irq_ctrl.sv | 116 +++++++++++
 tb/tb_cpu_68k_irq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_68k_irq_ctrl.sv
// rtl/cpu_68k_irq_ctrl.sv - 68k interrupt priority encoder with pending latch, mask and autovector IACK FSM
//
// Optional feature macro: CPU_68K_IRQ_AUTOACK_EN
//   defined   : an IACK cycle clears the pending bit of the acknowledged level on entry
//   undefined : IACK cycles never touch pending; only ACK_WE clears
//
// Ports:
//   CLK_68KCLK    in   1        clock, rising edge
//   RESET         in   1        synchronous active-high reset
//   IRQ_IN        in   NUM_IRQ  rising-edge interrupt requests
//   ACK_WE        in   1        write-1-to-clear strobe for pending bits
//   ACK_DATA      in   NUM_IRQ  pending bits to clear
//   MASK_WE       in   1        enable mask load strobe
//   MASK_DATA     in   NUM_IRQ  new enable mask
//   nAS           in   1        68k address strobe, active low
//   FC            in   3        68k function code
//   M68K_ADDR_LO  in   3        68k A3..A1 (interrupt level during IACK)
//   nIPL          out  3        registered active-low priority level
//   nVPA          out  1        active-low autovector request
//   PENDING       out  NUM_IRQ  raw pending bits
module cpu_68k_irq_ctrl #(
  parameter int                   NUM_IRQ  = 3,
  parameter logic [NUM_IRQ-1:0]   MASK_RST = {NUM_IRQ{1'b1}}
) (
  input  logic               CLK_68KCLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  input  logic               ACK_WE,
  input  logic [NUM_IRQ-1:0] ACK_DATA,
  input  logic               MASK_WE,
  input  logic [NUM_IRQ-1:0] MASK_DATA,
  input  logic               nAS,
  input  logic [2:0]         FC,
  input  logic [2:0]         M68K_ADDR_LO,
  output logic [2:0]         nIPL,
  output logic               nVPA,
  output logic [NUM_IRQ-1:0] PENDING
);

  typedef enum logic {ST_IDLE = 1'b0, ST_IACK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [2:0]         nipl_q;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] clr;
  logic [2:0]         act_lvl;
  logic               iack_start;

  assign irq_rise   = IRQ_IN & ~irq_q;
  assign iack_start = (state_q == ST_IDLE) && (state_d == ST_IACK);

  // Clear sources; set is OR-ed in after the clear so a coincident edge wins.
  always_comb begin
    clr = ACK_WE ? ACK_DATA : '0;
`ifdef CPU_68K_IRQ_AUTOACK_EN
    // Levels 0 and > NUM_IRQ match no channel, so they clear nothing.
    for (int i = 0; i < NUM_IRQ; i++)
      if (iack_start && (M68K_ADDR_LO == 3'(i + 1))) clr[i] = 1'b1;
`endif
  end

`ifndef CPU_68K_IRQ_AUTOACK_EN
  logic unused_addr;
  assign unused_addr = ^{M68K_ADDR_LO, iack_start};
`endif

  // Highest enabled pending channel wins; level is channel index + 1.
  always_comb begin
    act_lvl = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (pend_q[i] && mask_q[i]) act_lvl = 3'(i + 1);
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      irq_q  <= '0;
      pend_q <= '0;
      mask_q <= MASK_RST;
      nipl_q <= 3'b111;
    end else begin
      irq_q  <= IRQ_IN;
      pend_q <= (pend_q & ~clr) | irq_rise;
      if (MASK_WE) mask_q <= MASK_DATA;
      nipl_q <= ~act_lvl;
    end
  end

  // IACK FSM: state register
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // IACK FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!nAS && (FC == 3'b111)) state_d = ST_IACK;
      ST_IACK: if (nAS)                    state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // IACK FSM: outputs
  always_comb begin
    nVPA = 1'b1;
    if (state_q == ST_IACK) nVPA = 1'b0;
  end

  assign nIPL    = nipl_q;
  assign PENDING = pend_q;

endmodule

// File: tb/tb_cpu_68k_irq_ctrl.sv
// tb/tb_cpu_68k_irq_ctrl.sv - directed self-checking bench for cpu_68k_irq_ctrl
module tb_cpu_68k_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] irq_in;
  logic       ack_we;
  logic [2:0] ack_data;
  logic       mask_we;
  logic [2:0] mask_data;
  logic       n_as;
  logic [2:0] fc;
  logic [2:0] addr_lo;
  logic [2:0] n_ipl;
  logic       n_vpa;
  logic [2:0] pending;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef CPU_68K_IRQ_AUTOACK_EN
  localparam logic [2:0] IACK3_PEND = 3'b000;
`else
  localparam logic [2:0] IACK3_PEND = 3'b100;
`endif

  cpu_68k_irq_ctrl #(.NUM_IRQ(3)) dut (
    .CLK_68KCLK   (clk),
    .RESET        (rst),
    .IRQ_IN       (irq_in),
    .ACK_WE       (ack_we),
    .ACK_DATA     (ack_data),
    .MASK_WE      (mask_we),
    .MASK_DATA    (mask_data),
    .nAS          (n_as),
    .FC           (fc),
    .M68K_ADDR_LO (addr_lo),
    .nIPL         (n_ipl),
    .nVPA         (n_vpa),
    .PENDING      (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 3'b000; ack_we = 1'b0; ack_data = 3'b000;
    mask_we = 1'b0; mask_data = 3'b000; n_as = 1'b1; fc = 3'b000; addr_lo = 3'd0;
    tick(); tick();
    chk("rst_pending", 8'(pending), 8'h0);
    chk("rst_nipl",    8'(n_ipl),   8'h7);
    chk("rst_nvpa",    8'(n_vpa),   8'h1);

    // IRQ high right at reset release counts as an edge
    rst = 1'b0; irq_in = 3'b001;
    tick();
    chk("edge0_pending", 8'(pending), 8'h1);
    chk("edge0_nipl_lag", 8'(n_ipl),  8'h7);
    tick();
    chk("edge0_nipl", 8'(n_ipl), 8'h6);

    // Held-high line does not re-set after clear
    ack_we = 1'b1; ack_data = 3'b001;
    tick();
    chk("ack0_pending", 8'(pending), 8'h0);
    ack_we = 1'b0;
    tick();
    chk("held_no_reset", 8'(pending), 8'h0);
    chk("ack0_nipl",     8'(n_ipl),   8'h7);

    // Level 1 then level 3 arrives
    irq_in = 3'b000; tick();
    irq_in = 3'b001; tick();
    irq_in = 3'b101; tick();
    chk("p101", 8'(pending), 8'h5);
    tick();
    chk("lvl3_nipl", 8'(n_ipl), 8'h4);
    ack_we = 1'b1; ack_data = 3'b100;
    tick();
    chk("ack2_pending", 8'(pending), 8'h1);
    ack_we = 1'b0;
    tick();
    chk("ack2_nipl", 8'(n_ipl), 8'h6);

    // Mask gates level only
    irq_in = 3'b000; tick();
    irq_in = 3'b100; tick();
    chk("p101_again", 8'(pending), 8'h5);
    mask_we = 1'b1; mask_data = 3'b000; tick();
    mask_we = 1'b0; tick();
    chk("mask0_nipl",    8'(n_ipl),   8'h7);
    chk("mask0_pending", 8'(pending), 8'h5);
    mask_we = 1'b1; mask_data = 3'b111; tick();
    mask_we = 1'b0; tick();
    chk("mask7_nipl", 8'(n_ipl), 8'h4);

    // IACK at level 3 with pending 100
    ack_we = 1'b1; ack_data = 3'b001; tick();
    ack_we = 1'b0; irq_in = 3'b000;
    chk("pre_iack_pending", 8'(pending), 8'h4);
    n_as = 1'b0; fc = 3'b111; addr_lo = 3'd3;
    tick();
    chk("iack3_nvpa",    8'(n_vpa),   8'h0);
    chk("iack3_pending", 8'(pending), 8'(IACK3_PEND));
    tick();
    chk("iack3_hold", 8'(n_vpa), 8'h0);
    n_as = 1'b1; fc = 3'b000;
    tick();
    chk("iack3_end_nvpa",    8'(n_vpa),   8'h1);
    chk("iack3_end_pending", 8'(pending), 8'(IACK3_PEND));

    // Non-IACK bus cycle
    n_as = 1'b0; fc = 3'b101;
    tick();
    chk("noniack_nvpa", 8'(n_vpa), 8'h1);
    n_as = 1'b1; fc = 3'b000;

    // Out-of-range IACK levels: nVPA still asserted, nothing cleared
    irq_in = 3'b100; tick();
    irq_in = 3'b000;
    chk("re_p100", 8'(pending), 8'h4);
    n_as = 1'b0; fc = 3'b111; addr_lo = 3'd0;
    tick();
    chk("iack0_nvpa",    8'(n_vpa),   8'h0);
    chk("iack0_pending", 8'(pending), 8'h4);
    n_as = 1'b1; tick();
    n_as = 1'b0; addr_lo = 3'd5;
    tick();
    chk("iack5_nvpa",    8'(n_vpa),   8'h0);
    chk("iack5_pending", 8'(pending), 8'h4);
    n_as = 1'b1; fc = 3'b000; tick();
    chk("iack5_end_nvpa", 8'(n_vpa), 8'h1);

    // Set wins over coincident ACK clear
    irq_in = 3'b001; ack_we = 1'b1; ack_data = 3'b001;
    tick();
    chk("set_wins", 8'(pending), 8'h5);
    ack_we = 1'b0;
    tick();
    chk("set_wins_nipl", 8'(n_ipl), 8'h4);

    // Reset aborts an IACK cycle
    n_as = 1'b0; fc = 3'b111; addr_lo = 3'd1;
    tick();
    chk("iack1_nvpa", 8'(n_vpa), 8'h0);
    rst = 1'b1;
    tick();
    chk("rst_iack_nvpa",    8'(n_vpa),   8'h1);
    chk("rst_iack_nipl",    8'(n_ipl),   8'h7);
    chk("rst_iack_pending", 8'(pending), 8'h0);
    rst = 1'b0; n_as = 1'b1; fc = 3'b000;
    tick();
    chk("post_rst_edge", 8'(pending), 8'h1);
    chk("post_rst_nvpa", 8'(n_vpa),   8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
